// File: rtl/formula_n_isqrt_acc_fsm_pkg.sv
// Shared types for the N-argument isqrt accumulator: FSM states, reduction modes
// and the result-width rule used by both the interface and the datapath.
package formula_n_isqrt_acc_fsm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        MODE_SUM = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    // Wide enough that the sum of N roots of W/2 bits never overflows.
    function automatic int res_width(input int n, input int w);
        return w / 2 + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/formula_n_isqrt_acc_fsm_if.sv
// Argument/result handshake plus the request/response link to the shared isqrt pipe.
interface formula_n_isqrt_acc_fsm_if
    import formula_n_isqrt_acc_fsm_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 32
);
    localparam int RES_W = res_width(N, W);

    // A bundle transfers on a cycle with arg_vld & arg_rdy; res_vld and
    // isqrt_x_vld are single-cycle pulses with no back-pressure, and the isqrt
    // pipe returns exactly one isqrt_y_vld pulse per request, in order.
    logic             arg_vld;
    logic             arg_rdy;
    logic [N*W-1:0]   args;
    logic             mode;
    logic             res_vld;
    logic [RES_W-1:0] res;
    logic             isqrt_x_vld;
    logic [W-1:0]     isqrt_x;
    logic             isqrt_y_vld;
    logic [W/2-1:0]   isqrt_y;

    modport master (
        input  arg_vld, args, mode, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );

    modport slave (
        output arg_vld, args, mode, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );

endinterface

// File: rtl/formula_n_isqrt_acc_fsm.sv
// Streams N captured arguments through one shared isqrt pipe, one request in
// flight at a time, and reduces the roots by sum or max into a registered result.
module formula_n_isqrt_acc_fsm
    import formula_n_isqrt_acc_fsm_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    formula_n_isqrt_acc_fsm_if.master  bus,
    output state_e                     state_o
);
    localparam int RES_W = res_width(N, W);
    localparam int CW    = (N > 1) ? $clog2(N) : 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [RES_W-1:0] acc_q;
    logic [N*W-1:0]   args_q;
    mode_e            mode_q;
    logic [RES_W-1:0] res_q;
    logic             res_vld_q;

    logic             arg_rdy;
    logic             accept;
    logic             resp;
    logic             last;
    logic             issue_next;
    logic [RES_W-1:0] y_ext;
    logic [RES_W-1:0] acc_upd;
    logic [CW-1:0]    sel;
    int               sel_idx;

    always_comb begin
        arg_rdy    = (state_q == ST_IDLE);
        accept     = bus.arg_vld && arg_rdy;
        resp       = (state_q == ST_WAIT) && bus.isqrt_y_vld;
        last       = (cnt_q == CW'(N - 1));
        issue_next = resp && !last;
        y_ext      = RES_W'(bus.isqrt_y);
        if (mode_q == MODE_MAX) begin
            acc_upd = (y_ext > acc_q) ? y_ext : acc_q;
        end else begin
            acc_upd = acc_q + y_ext;
        end
        // The next operand goes out in the same cycle its predecessor's root lands.
        sel     = issue_next ? (cnt_q + CW'(1)) : cnt_q;
        sel_idx = int'(sel) * W;
        bus.isqrt_x_vld = accept || issue_next;
        bus.isqrt_x     = accept ? bus.args[W-1:0] : args_q[sel_idx +: W];
        bus.arg_rdy     = arg_rdy;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            args_q    <= '0;
            mode_q    <= MODE_SUM;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        args_q  <= bus.args;
                        mode_q  <= mode_e'(bus.mode);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp) begin
                        acc_q <= acc_upd;
                        if (last) begin
                            state_q   <= ST_IDLE;
                            res_q     <= acc_upd;
                            res_vld_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.res     = res_q;
    assign bus.res_vld = res_vld_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_formula_n_isqrt_acc_fsm.sv
// Bench for the isqrt accumulator: N=3 and N=1 instances, behavioural isqrt pipe
// with random 1..8 cycle latency, request-order and result scoreboards.
module tb_formula_n_isqrt_acc_fsm;
    import formula_n_isqrt_acc_fsm_pkg::*;

    localparam int W   = 32;
    localparam int N0  = 3;
    localparam int N1  = 1;
    localparam int RW0 = W / 2 + $clog2(N0 + 1);
    localparam int RW1 = W / 2 + $clog2(N1 + 1);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    formula_n_isqrt_acc_fsm_if #(.N(N0), .W(W)) bus0 ();
    formula_n_isqrt_acc_fsm_if #(.N(N1), .W(W)) bus1 ();
    state_e st0, st1;

    formula_n_isqrt_acc_fsm #(.N(N0), .W(W)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0), .state_o(st0));
    formula_n_isqrt_acc_fsm #(.N(N1), .W(W)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1), .state_o(st1));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [RW0-1:0] exp_q0[$];
    logic [RW1-1:0] exp_q1[$];
    logic [W-1:0]   req_q0[$];
    logic [W-1:0]   req_q1[$];
    int req_cnt0  = 0;
    int resp_cnt0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred that should not", name);
    endtask

    function automatic logic [15:0] isqrt32(input logic [31:0] x);
        logic [15:0] r = '0;
        logic [15:0] t;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= {32'd0, x}) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_res(input logic [N0*W-1:0] a, input int n, input logic m);
        logic [31:0] acc = '0;
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = {16'd0, isqrt32(a[i*W +: W])};
            acc = m ? ((r > acc) ? r : acc) : acc + r;
        end
        return acc;
    endfunction

    // ---------------- isqrt pipe model ----------------
    bit          busy_m[2];
    int          lat_m[2];
    logic [15:0] root_m[2];
    logic        yv0, yv1;
    logic [15:0] y0, y1;

    task automatic model_resp(input int k, output logic v, output logic [15:0] y);
        v = 1'b0;
        y = root_m[k];
        if (busy_m[k]) begin
            if (lat_m[k] <= 1) begin
                v = 1'b1;
                busy_m[k] = 1'b0;
            end else begin
                lat_m[k]--;
            end
        end
    endtask

    task automatic model_req(input int k, input logic [W-1:0] x);
        if (busy_m[k]) fail_now($sformatf("isqrt_overlap%0d", k));
        busy_m[k] = 1'b1;
        root_m[k] = isqrt32(x);
        lat_m[k]  = $urandom_range(1, 8);
    endtask

    always @(negedge clk) begin
        model_resp(0, yv0, y0);
        bus0.isqrt_y_vld = yv0;
        bus0.isqrt_y     = y0;
        if (yv0) resp_cnt0++;
        model_resp(1, yv1, y1);
        bus1.isqrt_y_vld = yv1;
        bus1.isqrt_y     = y1;
        #1;
        if (bus0.isqrt_x_vld) begin
            model_req(0, bus0.isqrt_x);
            req_cnt0++;
            if (req_q0.size() == 0) fail_now("unexpected_req0");
            else check("req_order0", bus0.isqrt_x, req_q0.pop_front());
        end
        if (bus1.isqrt_x_vld) begin
            model_req(1, bus1.isqrt_x);
            if (req_q1.size() == 0) fail_now("unexpected_req1");
            else check("req_order1", bus1.isqrt_x, req_q1.pop_front());
        end
        #1;
        if (bus0.res_vld) begin
            if (exp_q0.size() == 0) fail_now("unexpected_res0");
            else check("res0", bus0.res, exp_q0.pop_front());
        end
        if (bus1.res_vld) begin
            if (exp_q1.size() == 0) fail_now("unexpected_res1");
            else check("res1", bus1.res, exp_q1.pop_front());
        end
    end

    // ---------------- drivers (called at a negedge) ----------------
    task automatic drive0(input logic [N0*W-1:0] a, input logic m, input logic [RW0-1:0] e);
        int g = 0;
        bus0.args = a;
        bus0.mode = m;
        bus0.arg_vld = 1'b1;
        while (!bus0.arg_rdy && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            fail_now("accept_timeout0");
            bus0.arg_vld = 1'b0;
        end else begin
            exp_q0.push_back(e);
            for (int i = 0; i < N0; i++) req_q0.push_back(a[i*W +: W]);
            @(posedge clk);
            #1;
            bus0.arg_vld = 1'b0;
            bus0.args = {$urandom, $urandom, $urandom};
            bus0.mode = ~m;
        end
    endtask

    task automatic drive1(input logic [W-1:0] a, input logic m, input logic [RW1-1:0] e);
        int g = 0;
        bus1.args = a;
        bus1.mode = m;
        bus1.arg_vld = 1'b1;
        while (!bus1.arg_rdy && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            fail_now("accept_timeout1");
            bus1.arg_vld = 1'b0;
        end else begin
            exp_q1.push_back(e);
            req_q1.push_back(a);
            @(posedge clk);
            #1;
            bus1.arg_vld = 1'b0;
            bus1.args = $urandom;
            bus1.mode = ~m;
        end
    endtask

    task automatic wait_done0();
        int g = 0;
        while (exp_q0.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) fail_now("done_timeout0");
    endtask

    task automatic wait_done1();
        int g = 0;
        while (exp_q1.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) fail_now("done_timeout1");
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [N0*W-1:0] args;
        logic            mode;
        logic [RW0-1:0]  exp;
    } vec0_t;

    vec0_t vecs[7];

    initial begin
        int base;
        int g;
        logic [N0*W-1:0] ra;
        logic rm;
        logic [W-1:0] rx;

        vecs[0] = '{{32'd16, 32'd9, 32'd4},    MODE_SUM, 18'd9};
        vecs[1] = '{{32'd1, 32'd100, 32'd49},  MODE_MAX, 18'd10};
        vecs[2] = '{{3{32'hFFFF_FFFF}},        MODE_SUM, 18'd196605};
        vecs[3] = '{{32'd0, 32'd0, 32'd0},     MODE_SUM, 18'd0};
        vecs[4] = '{{32'd15, 32'd8, 32'd3},    MODE_SUM, 18'd6};
        vecs[5] = '{{32'd24, 32'd99, 32'd0},   MODE_MAX, 18'd9};
        vecs[6] = '{{32'd0, 32'd0, 32'hFFFF_FFFF}, MODE_MAX, 18'd65535};

        bus0.arg_vld = 1'b0; bus0.args = '0; bus0.mode = 1'b0;
        bus1.arg_vld = 1'b0; bus1.args = '0; bus1.mode = 1'b0;
        bus0.isqrt_y_vld = 1'b0; bus0.isqrt_y = '0;
        bus1.isqrt_y_vld = 1'b0; bus1.isqrt_y = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_arg_rdy", bus0.arg_rdy, 1);
        check("rst_res_vld", bus0.res_vld, 0);
        check("rst_res", bus0.res, 0);
        check("rst_x_vld", bus0.isqrt_x_vld, 0);
        check("rst_state", st0, ST_IDLE);
        check("rst_arg_rdy1", bus1.arg_rdy, 1);
        rst_n = 1'b1;

        // table-driven: each bundle issues exactly N requests
        foreach (vecs[i]) begin
            @(negedge clk);
            base = req_cnt0;
            drive0(vecs[i].args, vecs[i].mode, vecs[i].exp);
            wait_done0();
            check($sformatf("req_count_v%0d", i), req_cnt0 - base, N0);
        end

        // bundle offered while busy is ignored; next one lands in the res_vld cycle
        @(negedge clk);
        drive0({32'd49, 32'd36, 32'd25}, MODE_SUM, 18'd18);
        bus0.arg_vld = 1'b1;
        bus0.args = {32'd10000, 32'd10000, 32'd10000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_arg_rdy", bus0.arg_rdy, 0);
            check("busy_state", st0, ST_WAIT);
        end
        bus0.arg_vld = 1'b0;
        g = 0;
        while (!bus0.res_vld && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) fail_now("res_vld_timeout");
        check("b2b_arg_rdy", bus0.arg_rdy, 1);
        drive0({32'd0, 32'd0, 32'd25}, MODE_SUM, 18'd5);
        wait_done0();

        // reset after the second response aborts the operation
        @(negedge clk);
        base = resp_cnt0;
        drive0({32'd9, 32'd4, 32'd1}, MODE_SUM, 18'd6);
        g = 0;
        while (resp_cnt0 < base + 2 && g < 200) begin
            @(negedge clk);
            #3;
            g++;
        end
        if (g >= 200) fail_now("resp_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        exp_q0.delete();
        req_q0.delete();
        #1;
        check("abort_state", st0, ST_IDLE);
        check("abort_arg_rdy", bus0.arg_rdy, 1);
        check("abort_res", bus0.res, 0);
        check("abort_x_vld", bus0.isqrt_x_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("late_resp_res", bus0.res, 0);
        drive0({32'd1, 32'd1, 32'd1}, MODE_SUM, 18'd3);
        wait_done0();

        // random bundles on the N=3 instance
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ra = (i % 2 == 0) ? {$urandom, $urandom, $urandom}
                              : {32'($urandom_range(0, 400)), 32'($urandom_range(0, 400)),
                                 32'($urandom_range(0, 400))};
            rm = 1'($urandom_range(0, 1));
            drive0(ra, rm, RW0'(ref_res(ra, N0, rm)));
            wait_done0();
        end

        // N=1 instance
        @(negedge clk);
        drive1(32'd1_000_000, MODE_SUM, 17'd1000);
        wait_done1();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rx = (i % 3 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            rm = 1'($urandom_range(0, 1));
            drive1(rx, rm, RW1'(ref_res({64'd0, rx}, N1, rm)));
            if (i % 4 != 0) wait_done1();
        end
        wait_done1();

        repeat (12) @(negedge clk);
        check("exp_q0_empty", exp_q0.size(), 0);
        check("exp_q1_empty", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
